// File: rtl/del_ctrl_fsm.sv
// Delete sub-controller: looks up a key and invalidates the hit entry; req one cycle after accept, result 1 cycle after the response.
// No backpressure: lookup response is awaited for at most TIMEOUT cycles, status/del strobes are single-cycle and unconditioned.
module del_ctrl_fsm #(
  parameter int NUM_ENTRIES = 16,
  parameter int KEY_WIDTH   = 16,
  parameter int TIMEOUT     = 8,
  localparam int IDX_W      = (NUM_ENTRIES > 1) ? $clog2(NUM_ENTRIES) : 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 en,
  input  logic [KEY_WIDTH-1:0] key_in,
  output logic                 lookup_req,
  output logic [KEY_WIDTH-1:0] lookup_key,
  input  logic                 lookup_valid,
  input  logic                 lookup_hit,
  input  logic [IDX_W-1:0]     lookup_idx,
  output logic                 del_we,
  output logic [IDX_W-1:0]     del_idx,
  output logic [1:0]           status,
  output logic                 busy
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    DEL_ST_START  = 2'd0,
    DEL_ST_DELETE = 2'd1,
    DEL_ST_ERROR  = 2'd2
  } del_substate_e;

  typedef struct packed {
    logic done;
    logic error;
  } sub_cmd_t;

  del_substate_e        state_q, state_d;
  logic                 armed_q, armed_d;
  logic                 waiting_q, waiting_d;
  logic                 req_q, req_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [KEY_WIDTH-1:0] key_q, key_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic                 idx_ok;
  sub_cmd_t             sub_cmd;

  assign idx_ok = int'(32'(lookup_idx)) < NUM_ENTRIES;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= DEL_ST_START;
      armed_q   <= 1'b1;
      waiting_q <= 1'b0;
      req_q     <= 1'b0;
      cnt_q     <= '0;
      key_q     <= '0;
      idx_q     <= '0;
    end else begin
      state_q   <= state_d;
      armed_q   <= armed_d;
      waiting_q <= waiting_d;
      req_q     <= req_d;
      cnt_q     <= cnt_d;
      key_q     <= key_d;
      idx_q     <= idx_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    armed_d   = armed_q;
    waiting_d = waiting_q;
    req_d     = 1'b0;
    cnt_d     = cnt_q;
    key_d     = key_q;
    idx_d     = idx_q;

    // Seeing en low is the only thing that re-arms, whatever the state.
    if (!en) armed_d = 1'b1;

    unique case (state_q)
      DEL_ST_START: begin
        if (!waiting_q) begin
          if (armed_q && en) begin
            key_d     = key_in;
            waiting_d = 1'b1;
            armed_d   = 1'b0;
            req_d     = 1'b1;
            cnt_d     = '0;
          end
        end else if (!en) begin
          waiting_d = 1'b0;
          cnt_d     = '0;
        end else if (!req_q) begin
          // Response window; a response in the req cycle itself is ignored.
          if (lookup_valid) begin
            waiting_d = 1'b0;
            cnt_d     = '0;
            if (lookup_hit && idx_ok) begin
              idx_d   = lookup_idx;
              state_d = DEL_ST_DELETE;
            end else begin
              state_d = DEL_ST_ERROR;
            end
          end else if (cnt_q == CNT_LAST) begin
            waiting_d = 1'b0;
            cnt_d     = '0;
            state_d   = DEL_ST_ERROR;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      DEL_ST_DELETE: state_d = DEL_ST_START;
      DEL_ST_ERROR:  state_d = DEL_ST_START;
      default:       state_d = DEL_ST_START;
    endcase
  end

  always_comb begin
    sub_cmd       = '0;
    sub_cmd.done  = (state_q == DEL_ST_DELETE);
    sub_cmd.error = (state_q == DEL_ST_ERROR);
  end

  assign status     = sub_cmd;
  assign del_we     = (state_q == DEL_ST_DELETE);
  assign del_idx    = del_we ? idx_q : '0;
  assign lookup_req = req_q;
  assign lookup_key = key_q;
  assign busy       = waiting_q | (state_q != DEL_ST_START);

endmodule

// File: tb/tb_del_ctrl_fsm.sv
// Bench for del_ctrl_fsm: directed scenarios with literal expectations, then random traffic
// checked every cycle against a timeline model (accept / req / result cycle numbers).
module tb_del_ctrl_fsm;

  localparam int N   = 12;
  localparam int KW  = 16;
  localparam int T   = 8;
  localparam int IW  = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          en = 1'b0;
  logic [KW-1:0] key_in = '0;
  logic          lookup_req;
  logic [KW-1:0] lookup_key;
  logic          lookup_valid = 1'b0;
  logic          lookup_hit = 1'b0;
  logic [IW-1:0] lookup_idx = '0;
  logic          del_we;
  logic [IW-1:0] del_idx;
  logic [1:0]    status;
  logic          busy;

  int n_chk  = 0;
  int n_fail = 0;

  del_ctrl_fsm #(.NUM_ENTRIES(N), .KEY_WIDTH(KW), .TIMEOUT(T)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .key_in(key_in),
    .lookup_req(lookup_req), .lookup_key(lookup_key),
    .lookup_valid(lookup_valid), .lookup_hit(lookup_hit), .lookup_idx(lookup_idx),
    .del_we(del_we), .del_idx(del_idx), .status(status), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
    end
  endtask

  // Timeline model: a command is a set of cycle numbers, not a state machine.
  int            cyc      = 0;
  bit            m_active = 1'b0;
  bit            m_armed  = 1'b1;
  int            req_cyc  = -100;
  int            res_cyc  = -100;
  bit            res_ok   = 1'b0;
  int            res_idx  = 0;
  logic [KW-1:0] m_key    = '0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_active = 1'b0;
      m_armed  = 1'b1;
      req_cyc  = -100;
      res_cyc  = -100;
    end else begin
      int  c;
      bit  acc;
      c   = cyc;
      acc = 1'b0;
      if (m_active) begin
        if (!en) begin
          m_active = 1'b0;
        end else if (c > req_cyc) begin
          if (lookup_valid) begin
            m_active = 1'b0;
            res_cyc  = c + 1;
            res_ok   = lookup_hit && (int'(32'(lookup_idx)) < N);
            res_idx  = int'(32'(lookup_idx));
          end else if (c - req_cyc == T) begin
            m_active = 1'b0;
            res_cyc  = c + 1;
            res_ok   = 1'b0;
          end
        end
      end else if (res_cyc != c && m_armed && en) begin
        acc      = 1'b1;
        m_active = 1'b1;
        req_cyc  = c + 1;
        m_key    = key_in;
      end
      if (acc) m_armed = 1'b0;
      else if (!en) m_armed = 1'b1;
      cyc = c + 1;
    end
  end

  always @(negedge clk) begin
    bit e_req, e_res, e_we, e_err, e_busy;
    e_req  = m_active && (cyc == req_cyc);
    e_res  = (cyc == res_cyc);
    e_we   = e_res && res_ok;
    e_err  = e_res && !res_ok;
    e_busy = m_active || e_res;
    chk("m_req",    32'(lookup_req), 32'(e_req));
    chk("m_del_we", 32'(del_we),     32'(e_we));
    chk("m_status", 32'(status),     32'({e_we, e_err}));
    chk("m_busy",   32'(busy),       32'(e_busy));
    if (e_req) chk("m_key", 32'(lookup_key), 32'(m_key));
    if (e_we)  chk("m_idx", 32'(del_idx),    32'(res_idx));
  end

  initial begin
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Hit: accept at 0, response at 3, delete at 4.
    @(negedge clk); en = 1'b1; key_in = 16'h00AB;
    @(negedge clk);
    chk("hit_req1", 32'(lookup_req), 32'h1);
    chk("hit_key",  32'(lookup_key), 32'h00AB);
    chk("hit_busy1", 32'(busy), 32'h1);
    key_in = 16'h1234;
    @(negedge clk);
    chk("hit_req2", 32'(lookup_req), 32'h0);
    chk("hit_key_stable", 32'(lookup_key), 32'h00AB);
    @(negedge clk); lookup_valid = 1'b1; lookup_hit = 1'b1; lookup_idx = 4'd5;
    @(negedge clk); lookup_valid = 1'b0; lookup_hit = 1'b0; lookup_idx = '0;
    chk("hit_we",     32'(del_we),  32'h1);
    chk("hit_idx",    32'(del_idx), 32'h5);
    chk("hit_done",   32'(status),  32'h2);
    @(negedge clk);
    chk("hit_busy5",  32'(busy),    32'h0);
    chk("hit_we5",    32'(del_we),  32'h0);
    repeat (4) begin
      @(negedge clk);
      chk("hold_no_req", 32'(lookup_req), 32'h0);
    end

    // Re-arm after one low cycle, then a miss at req+1.
    @(negedge clk); en = 1'b0;
    @(negedge clk); en = 1'b1; key_in = 16'h0F0F;
    @(negedge clk);
    chk("rearm_req", 32'(lookup_req), 32'h1);
    chk("rearm_key", 32'(lookup_key), 32'h0F0F);
    @(negedge clk); lookup_valid = 1'b1; lookup_hit = 1'b0;
    @(negedge clk); lookup_valid = 1'b0;
    chk("miss_err", 32'(status), 32'h1);
    chk("miss_we",  32'(del_we), 32'h0);
    @(negedge clk);
    chk("miss_err_once", 32'(status), 32'h0);
    chk("miss_busy",     32'(busy),   32'h0);

    // Timeout: no response, error lands at cycle 10.
    @(negedge clk); en = 1'b0;
    @(negedge clk); en = 1'b1; key_in = 16'h5555;
    for (int i = 1; i <= 9; i++) begin
      @(negedge clk);
      chk("to_quiet", 32'(status), 32'h0);
      chk("to_busy",  32'(busy),   32'h1);
    end
    @(negedge clk);
    chk("to_err", 32'(status), 32'h1);
    @(negedge clk); lookup_valid = 1'b1; lookup_hit = 1'b1; lookup_idx = 4'd3;
    chk("to_busy_off", 32'(busy), 32'h0);
    @(negedge clk); lookup_valid = 1'b0; lookup_hit = 1'b0;
    chk("to_late_we",  32'(del_we), 32'h0);
    chk("to_late_st",  32'(status), 32'h0);

    // Index out of range hit.
    @(negedge clk); en = 1'b0;
    @(negedge clk); en = 1'b1; key_in = 16'h7777;
    @(negedge clk);
    @(negedge clk); lookup_valid = 1'b1; lookup_hit = 1'b1; lookup_idx = 4'd13;
    @(negedge clk); lookup_valid = 1'b0; lookup_hit = 1'b0; lookup_idx = '0;
    chk("range_err", 32'(status), 32'h1);
    chk("range_we",  32'(del_we), 32'h0);

    // Abort in the window, late hit ignored.
    @(negedge clk); en = 1'b0;
    @(negedge clk); en = 1'b1; key_in = 16'h3C3C;
    @(negedge clk);
    chk("ab_req", 32'(lookup_req), 32'h1);
    @(negedge clk);
    @(negedge clk); en = 1'b0;
    @(negedge clk);
    chk("ab_busy", 32'(busy), 32'h0);
    lookup_valid = 1'b1; lookup_hit = 1'b1; lookup_idx = 4'd2;
    @(negedge clk); lookup_valid = 1'b0; lookup_hit = 1'b0; lookup_idx = '0;
    chk("ab_we", 32'(del_we), 32'h0);
    chk("ab_st", 32'(status), 32'h0);
    @(negedge clk);
    chk("ab_we2", 32'(del_we), 32'h0);

    // Reset mid-window, then accept straight after release.
    @(negedge clk); en = 1'b1; key_in = 16'h2222;
    @(negedge clk);
    chk("rs_req", 32'(lookup_req), 32'h1);
    @(negedge clk);
    #1 rst_n = 1'b0;
    #1 chk("rs_outs_zero", 32'({lookup_req, del_we, status, busy, lookup_key, del_idx}), 32'h0);
    @(negedge clk);
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
    chk("rs_req_after", 32'(lookup_req), 32'h1);
    chk("rs_key_after", 32'(lookup_key), 32'h2222);
    en = 1'b0;

    // Random traffic against the model.
    for (int n = 0; n < 3000; n++) begin
      @(negedge clk);
      if (!rst_n) rst_n = 1'b1;
      en           = en ? ($urandom_range(0, 11) != 0) : ($urandom_range(0, 2) != 0);
      key_in       = KW'($urandom);
      lookup_valid = ($urandom_range(0, 4) == 0);
      lookup_hit   = ($urandom_range(0, 3) != 0);
      lookup_idx   = IW'($urandom_range(0, 15));
      if ($urandom_range(0, 299) == 0) #2 rst_n = 1'b0;
    end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/del_ctrl_fsm.md
# del_ctrl_fsm

Delete sub-controller of the cache controller. It runs while the top FSM sits in ST_DEL, looks up the supplied key in the key store, and invalidates the matching entry. It reports back to the top FSM through a sub_cmd_t {done, error} status word. Its state register is del_substate_e (DEL_ST_START, DEL_ST_DELETE, DEL_ST_ERROR) from ctrl_types_pkg.

## Interface
Parameters:
- NUM_ENTRIES, 16, number of cache entries; IDX_W = $clog2(NUM_ENTRIES)
- KEY_WIDTH, 16, key width in bits
- TIMEOUT, 8, maximum number of wait cycles for a lookup response (≥1)

Ports:
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- en  in  1  command enable from the top FSM; high while top state is ST_DEL
- key_in  in  KEY_WIDTH  key to delete; sampled when a command is accepted
- lookup_req  out  1  one-cycle lookup request to the key store
- lookup_key  out  KEY_WIDTH  latched key; stable from the req cycle until the command ends
- lookup_valid  in  1  lookup response strobe
- lookup_hit  in  1  key found (qualified by lookup_valid)
- lookup_idx  in  IDX_W  matching entry index (qualified by lookup_valid & lookup_hit)
- del_we  out  1  one-cycle invalidate strobe
- del_idx  out  IDX_W  entry to invalidate
- status  out  2  sub_cmd_t: bit1 done, bit0 error; each asserts for exactly one cycle
- busy  out  1  high from command acceptance until the cycle after done or error

## Operation
- Internal registers: state, armed, waiting, key_q, idx_q, wait counter cnt (width ≥ $clog2(TIMEOUT+1)).
- Reset values:
  - state = DEL_ST_START, armed = 1, waiting = 0, cnt = 0, key_q = 0, idx_q = 0.
  - All outputs are 0.
- Accept: in DEL_ST_START with waiting=0, armed=1 and en=1:
  - latch key_in into key_q;
  - set waiting=1 and armed=0;
  - lookup_req=1 in the next cycle, and only in that cycle.
- Wait: the lookup_valid accept window is cycles req+1 through req+TIMEOUT. lookup_valid in the req cycle itself is ignored. cnt increments each window cycle. Outcome of the first accepted lookup_valid:
  - hit with lookup_idx < NUM_ENTRIES: latch idx_q, go to DEL_ST_DELETE.
  - hit with lookup_idx ≥ NUM_ENTRIES: go to DEL_ST_ERROR.
  - miss: go to DEL_ST_ERROR.
  - no lookup_valid by the end of cycle req+TIMEOUT: go to DEL_ST_ERROR.
- DEL_ST_DELETE: for one cycle, del_we=1, del_idx=idx_q, status.done=1. Then go to DEL_ST_START with waiting=0.
- DEL_ST_ERROR: for one cycle, status.error=1 and del_we=0. Then go to DEL_ST_START.
- Re-arm: armed returns to 1 only after en is sampled low for at least one cycle. A held en never re-triggers a command.
- Abort: en=0 during the req cycle or the window clears waiting and cnt and re-arms the block. There is no done, no error and no del_we. A late lookup_valid after the abort is ignored.
- en=0 while in DEL_ST_DELETE or DEL_ST_ERROR does not cancel that cycle's strobe.
- status.done and status.error are mutually exclusive in every cycle.
- Asynchronous reset at any point forces the reset values immediately. An in-flight delete is dropped and no del_we is emitted.

## Timing
- Cycle A: en sampled high (command accepted). busy=1 from A+1.
- Cycle A+1: lookup_req=1 and lookup_key=key_q.
- lookup_valid at A+1+k (1 ≤ k ≤ TIMEOUT) → result cycle at A+2+k:
  - hit: del_we plus done;
  - miss: error.
- Timeout → error at A+2+TIMEOUT.
- busy falls in the cycle after the result cycle.
- Minimum command length: lookup_valid at A+2 gives done at A+3.
- Back-to-back commands: the earliest new acceptance is the first cycle with en high after en was seen low.

## Test plan
- Hit: key_in=0x00AB, en high at cycle 0, lookup_valid/hit/idx=5 at cycle 3 → lookup_req only at cycle 1 with lookup_key=0x00AB; del_we=1, del_idx=5 and done=1 only at cycle 4; busy low at cycle 5.
- Miss: lookup_valid=1, hit=0 at cycle 2 → error=1 at cycle 3 only; del_we never asserts.
- Timeout (TIMEOUT=8): no lookup_valid → error at cycle 10; lookup_valid=1 at cycle 11 is ignored.
- Index range (NUM_ENTRIES=12): hit with idx=13 → error; del_we stays 0.
- Hold and abort:
  - en held high after done → no second lookup_req;
  - en low for 1 cycle then high → new lookup_req one cycle later;
  - en dropped at cycle 2 of the wait → no strobes, and a later hit is ignored.
- Reset: rst_n asserted mid-window → all outputs 0 immediately. After release with en held high, a command is accepted and lookup_req follows.
